// File: rtl/blur_pkg.sv
// Shared definitions for the blur line feeder: FSM state encoding and
// counter-width helpers.
// Config macro honoured by users of this package: BLUR_BORDER_PAD_EN.
package blur_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Bits needed to count 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold 0..n inclusive (credit counters).
  function automatic int credit_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Widths for the default geometry (512x512 image, 4 line buffers).
  localparam int DEF_PIX_CNT_W  = cnt_width(512);
  localparam int DEF_LINE_CNT_W = cnt_width(512 + 2);
  localparam int DEF_CREDIT_W   = credit_width(4);

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered storage, full/empty flags.
// Ports: clk/rst, wr_en+wr_data (dropped when full), rd_en (ignored when
// empty), rd_data shows the head entry combinationally, full, empty.
module pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/blur_line_feeder.sv
// Upstream feeder for the 3x3 box blur: buffers a ready/valid pixel stream and
// releases whole lines under line-credit flow control (PRIME_LINES credits up
// front, one more per rising edge of rdBuffEmpty, saturating at PRIME_LINES).
// Ports: clk/rst (sync, active high), start, sPixel/sValid/sReady upstream,
// outPixel/outPixelValid to blur top, rdBuffEmpty from blur top, busy, frameDone.
// Config macro: BLUR_BORDER_PAD_EN adds an all-zero line before and after the frame.
module blur_line_feeder
  import blur_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LINES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] sPixel,
  input  logic                  sValid,
  output logic                  sReady,
  output logic [DATA_WIDTH-1:0] outPixel,
  output logic                  outPixelValid,
  input  logic                  rdBuffEmpty,
  output logic                  busy,
  output logic                  frameDone
);

`ifdef BLUR_BORDER_PAD_EN
  localparam int NUM_LINES = IMG_HEIGHT + 2;
`else
  localparam int NUM_LINES = IMG_HEIGHT;
`endif
  localparam int PW = cnt_width(IMG_WIDTH);
  localparam int LW = cnt_width(NUM_LINES);
  localparam int CW = credit_width(PRIME_LINES);

  state_t                  state;
  state_t                  state_nxt;
  logic [PW-1:0]           pix_cnt;
  logic [LW-1:0]           line_cnt;
  logic [CW-1:0]           line_credit;
  logic [CW-1:0]           credit_nxt;
  logic                    rbe_q;
  logic                    rbe_rise;
  logic                    pad_line;
  logic                    emit;
  logic                    pop;
  logic                    line_end;
  logic                    frame_end;
  logic [DATA_WIDTH-1:0]   fifo_rd_data;
  logic                    fifo_full;
  logic                    fifo_empty;

  pixel_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (sValid),
    .wr_data(sPixel),
    .rd_en  (pop),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Taken from the FIFO state before any same-cycle pop, so a full FIFO
  // refuses a push even on the cycle it is popped.
  assign sReady    = !fifo_full;
  assign busy      = (state == ST_STREAM);
  assign frameDone = (state == ST_DONE);

  always_comb begin
    pad_line = 1'b0;
`ifdef BLUR_BORDER_PAD_EN
    pad_line = (line_cnt == '0) || (line_cnt == LW'(NUM_LINES - 1));
`endif
    // Credit is checked per pixel, but only consumed at a line wrap, so a
    // line that has started keeps the credit it was granted until it ends.
    emit      = (state == ST_STREAM) && (line_credit != '0) && (pad_line || !fifo_empty);
    pop       = emit && !pad_line;
    line_end  = emit && (pix_cnt == PW'(IMG_WIDTH - 1));
    frame_end = line_end && (line_cnt == LW'(NUM_LINES - 1));
    rbe_rise  = rdBuffEmpty && !rbe_q;

    // A grant and a consumption on the same edge cancel out.
    credit_nxt = line_credit;
    if (rbe_rise && !line_end) begin
      if (line_credit != CW'(PRIME_LINES)) credit_nxt = line_credit + CW'(1);
    end else if (line_end && !rbe_rise) begin
      credit_nxt = line_credit - CW'(1);
    end

    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_STREAM;
      ST_STREAM: if (frame_end) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt       <= '0;
      line_cnt      <= '0;
      line_credit   <= CW'(PRIME_LINES);
      rbe_q         <= 1'b0;
      outPixel      <= '0;
      outPixelValid <= 1'b0;
    end else begin
      rbe_q         <= rdBuffEmpty;
      line_credit   <= credit_nxt;
      outPixelValid <= emit;
      if (emit) begin
        outPixel <= pad_line ? '0 : fifo_rd_data;
        if (line_end) begin
          pix_cnt  <= '0;
          line_cnt <= frame_end ? '0 : line_cnt + LW'(1);
        end else begin
          pix_cnt <= pix_cnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_blur_line_feeder.sv
// Bench for blur_line_feeder at 8x6 image, 4-entry FIFO, 4 line credits.
// Reference: expected output stream is the pushed pixels in order (with zero
// lines around them when BLUR_BORDER_PAD_EN), released 8 px per granted line.
module tb_blur_line_feeder;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int D  = 4;
  localparam int P  = 4;
`ifdef BLUR_BORDER_PAD_EN
  localparam int NL     = H + 2;
  localparam int PADOFF = W;
`else
  localparam int NL     = H;
  localparam int PADOFF = 0;
`endif
  localparam int TOTAL = NL * W;
  localparam int NDATA = H * W;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] sPixel;
  logic       sValid;
  logic       sReady;
  logic [7:0] outPixel;
  logic       outPixelValid;
  logic       rdBuffEmpty;
  logic       busy;
  logic       frameDone;

  always #5 clk = ~clk;

  blur_line_feeder #(
    .DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D), .PRIME_LINES(P)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sPixel(sPixel), .sValid(sValid),
    .sReady(sReady), .outPixel(outPixel), .outPixelValid(outPixelValid),
    .rdBuffEmpty(rdBuffEmpty), .busy(busy), .frameDone(frameDone)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int src[$];
  int got[$];
  int exp_q[$];
  int out_cyc[$];
  int acc_cyc[$];
  int acc_cnt = 0;
  int fd_cnt  = 0;
  bit feed_en = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_seq(input string tag, input int n);
    int mism = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= got.size() || i >= exp_q.size()) mism++;
      else if (got[i] != exp_q[i]) mism++;
    end
    chk(tag, mism, 0);
  endtask

  // One clock: handshake decided from pre-edge values, outputs sampled 1 unit after the edge.
  task automatic tick();
    bit fire;
    fire = sValid && sReady;
    @(posedge clk);
    cyc++;
    if (fire) begin
      void'(src.pop_front());
      acc_cnt++;
      acc_cyc.push_back(cyc);
    end
    #1;
    if (outPixelValid) begin
      got.push_back(int'(outPixel));
      out_cyc.push_back(cyc);
    end
    if (frameDone) fd_cnt++;
    sValid = feed_en && (src.size() > 0);
    sPixel = (src.size() > 0) ? 8'(src[0]) : 8'd0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_rbe();
    rdBuffEmpty = 1'b1;
    tick();
    rdBuffEmpty = 1'b0;
    tick();
  endtask

  task automatic gen(input int n);
    src.delete(); got.delete(); exp_q.delete(); out_cyc.delete(); acc_cyc.delete();
    acc_cnt = 0;
    fd_cnt  = 0;
    for (int i = 0; i < PADOFF; i++) exp_q.push_back(0);
    for (int i = 0; i < n; i++) begin
      int v;
      v = int'($urandom_range(255, 0));
      src.push_back(v);
      exp_q.push_back(v);
    end
    for (int i = 0; i < PADOFF; i++) exp_q.push_back(0);
  endtask

  task automatic reset_dut();
    feed_en = 1'b0;
    sValid  = 1'b0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int c0;
    int n0;
    bit reached;
    rst = 1'b1; start = 1'b0; sPixel = '0; sValid = 1'b0; rdBuffEmpty = 1'b0;
    run(3);
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_sReady", sReady, 1);
    chk("rst_valid", outPixelValid, 0);
    chk("rst_outPixel", outPixel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frameDone", frameDone, 0);

    // Test 1: prime credits release exactly four lines
    gen(NDATA);
    do_start();
    chk("t1_busy", busy, 1);
    feed_en = 1'b1;
    sValid  = 1'b1;
    sPixel  = 8'(src[0]);
    c0 = cyc;
    run(150);
    chk("t1_count", got.size(), P * W);
    chk_seq("t1_order", P * W);
`ifndef BLUR_BORDER_PAD_EN
    chk("t1_latency", (got.size() > 0) ? out_cyc[0] - c0 : -1, 2);
`endif
    chk("t1_sReady_full", sReady, 0);
    do_start();  // ignored while streaming
    run(20);
    chk("t1_hold", got.size(), P * W);
    chk("t1_still_busy", busy, 1);

    // Test 2: each rdBuffEmpty pulse releases one line; frame completes
    pulse_rbe();
    run(40);
    chk("t2_one_line", got.size(), (P + 1) * W);
    for (int k = 0; k < NL - P - 1; k++) begin
      pulse_rbe();
      run(40);
    end
    chk("t2_total", got.size(), TOTAL);
    chk_seq("t2_order", TOTAL);
    chk("t2_frameDone", fd_cnt, 1);
    chk("t2_idle", busy, 0);

    // Test 3: rdBuffEmpty held high for several cycles grants one credit
    reset_dut();
    gen(NDATA);
    do_start();
    feed_en = 1'b1;
    tick();
    run(150);
    chk("t3_prime", got.size(), P * W);
    rdBuffEmpty = 1'b1;
    run(5);
    rdBuffEmpty = 1'b0;
    run(40);
    chk("t3_held_one_line", got.size(), (P + 1) * W);
    for (int k = 0; k < NL - P - 1; k++) begin
      pulse_rbe();
      run(40);
    end
    chk("t3_total", got.size(), TOTAL);
    chk_seq("t3_order", TOTAL);

    // Test 4: no credit left, FIFO fills and backpressures
    gen(5);
    do_start();
    feed_en = 1'b1;
    tick();
    run(20);
    chk("t4_accepted", acc_cnt, D);
    chk("t4_sReady", sReady, 0);
    chk("t4_no_out", got.size(), 0);
    pulse_rbe();
    pulse_rbe();
    run(30);
    chk("t4_accept5", acc_cnt, 5);
    chk("t4_out_count", got.size(), PADOFF + 5);
    chk_seq("t4_order", PADOFF + 5);
    chk("t4_5th_after_pop",
        (acc_cyc.size() > 4 && out_cyc.size() > PADOFF) ? acc_cyc[4] - out_cyc[PADOFF] : -1, 1);

    // Reset in the middle of a line
    for (int i = 0; i < 20; i++) src.push_back(int'($urandom_range(255, 0)));
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      tick();
      if (outPixelValid && got.size() >= PADOFF + 7) reached = 1'b1;
    end
    chk("t4_midline_reached", reached, 1);
    feed_en = 1'b0;
    sValid  = 1'b0;
    rst     = 1'b1;
    tick();
    chk("rstmid_valid", outPixelValid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_sReady", sReady, 1);
    rst = 1'b0;
    tick();

    // Test 5: credit return lands on the same edge as the 4th line's last pixel
    gen(NDATA);
    feed_en = 1'b1;
    tick();
    run(6);  // preload FIFO while idle
    chk("t5_preload", acc_cnt, D);
    do_start();
    for (int i = 0; i < 200 && got.size() < P * W - 1; i++) tick();
    rdBuffEmpty = 1'b1;
    tick();
    rdBuffEmpty = 1'b0;
    chk("t5_edge_emit", got.size(), P * W);
    n0 = got.size();
    run(60);
    chk("t5_next_line", got.size(), (P + 1) * W);
    chk_seq("t5_order", (P + 1) * W);
    chk("t5_throughput", (n0 == P * W) ? out_cyc[P * W - 1] - out_cyc[0] : -1, P * W - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
